// File: rtl/dma_pkg.sv
// DMA engine shared definitions: FSM state type, register
// indices and CTRL/STATUS bit positions.
package dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_GO  = 0;
  localparam int CTRL_CLR = 1;

  // STATUS read bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

endpackage

// File: rtl/dma_regs.sv
// DMA register file: SRC/DST/LEN, DONE/ERR flags, read mux.
// Ports: clk, rst, i_a/i_we/i_wd (CPU write), o_rd (read data),
//   i_busy, i_done_set (from FSM), o_go, o_src, o_dst, o_len.
module dma_regs
  import dma_pkg::*;
#(
  parameter int AW = 6,
  parameter int LW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    i_a,
  input  logic          i_we,
  input  logic [31:0]   i_wd,
  output logic [31:0]   o_rd,
  input  logic          i_busy,
  input  logic          i_done_set,
  output logic          o_go,
  output logic [AW-1:0] o_src,
  output logic [AW-1:0] o_dst,
  output logic [LW-1:0] o_len
);

  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [LW-1:0] r_len;
  logic          r_done;
  logic          r_err;

  logic w_ctrl_wr;
  logic w_go;
  logic w_clr;
  logic w_cfg_wr;
  logic w_busy_wr;
  logic w_unused;

  assign w_ctrl_wr = i_we && (i_a == REG_CTRL);
  assign w_go      = w_ctrl_wr && i_wd[CTRL_GO] && !i_busy;
  assign w_clr     = w_ctrl_wr && i_wd[CTRL_CLR];
  assign w_cfg_wr  = i_we && !i_busy;

  // Config writes and GO are refused while a transfer runs;
  // a DONE clear alone is always allowed.
  assign w_busy_wr = i_we && i_busy &&
                     ((i_a != REG_CTRL) || i_wd[CTRL_GO]);

  assign w_unused  = ^i_wd[31:LW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_len  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_cfg_wr && (i_a == REG_SRC))
        r_src <= i_wd[AW-1:0];
      if (w_cfg_wr && (i_a == REG_DST))
        r_dst <= i_wd[AW-1:0];
      if (w_cfg_wr && (i_a == REG_LEN))
        r_len <= i_wd[LW-1:0];

      // GO outranks a clear in the same write; a zero
      // length completes immediately.
      if (w_go)
        r_done <= (r_len == '0);
      else if (i_done_set)
        r_done <= 1'b1;
      else if (w_clr)
        r_done <= 1'b0;

      if (w_go)
        r_err <= 1'b0;
      else if (w_busy_wr)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    o_rd = '0;
    unique case (1'b1)
      (i_a == REG_SRC):
        o_rd = {{(32-AW){1'b0}}, r_src};
      (i_a == REG_DST):
        o_rd = {{(32-AW){1'b0}}, r_dst};
      (i_a == REG_LEN):
        o_rd = {{(32-LW){1'b0}}, r_len};
      (i_a == REG_CTRL): begin
        o_rd[STAT_BUSY] = i_busy;
        o_rd[STAT_DONE] = r_done;
        o_rd[STAT_ERR]  = r_err;
      end
      default: o_rd = '0;
    endcase
  end

  assign o_go  = w_go;
  assign o_src = r_src;
  assign o_dst = r_dst;
  assign o_len = r_len;

endmodule

// File: rtl/dma_engine.sv
// Word-copy DMA engine: read/write FSM and datapath.
// Ports: clk, rst, A/WE/WD/RD (CPU regs), m_req/m_gnt
//   (dmem ownership), m_we/m_a/m_d/m_q (dmem port).
module dma_engine
  import dma_pkg::*;
#(
  parameter int AW = 6,
  parameter int LW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    A,
  input  logic          WE,
  input  logic [31:0]   WD,
  output logic [31:0]   RD,
  output logic          m_req,
  input  logic          m_gnt,
  output logic          m_we,
  output logic [AW-1:0] m_a,
  output logic [31:0]   m_d,
  input  logic [31:0]   m_q
);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_wsrc;
  logic [AW-1:0] r_wdst;
  logic [LW-1:0] r_wcnt;
  logic [31:0]   r_buf;

  logic          w_busy;
  logic          w_go;
  logic          w_start;
  logic          w_last;
  logic          w_done_set;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_dst;
  logic [LW-1:0] w_len;

  dma_regs #(
    .AW (AW),
    .LW (LW)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .i_a        (A),
    .i_we       (WE),
    .i_wd       (WD),
    .o_rd       (RD),
    .i_busy     (w_busy),
    .i_done_set (w_done_set),
    .o_go       (w_go),
    .o_src      (w_src),
    .o_dst      (w_dst),
    .o_len      (w_len)
  );

  assign w_start = w_go && (w_len != '0);
  assign w_last  = (r_wcnt == LW'(1));
  assign w_done_set = (r_state == S_WR) && m_gnt && w_last;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start) w_next = S_RD;
      S_RD:
        if (m_gnt) w_next = S_WR;
      S_WR:
        if (m_gnt) w_next = w_last ? S_IDLE : S_RD;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_req  = 1'b0;
    m_we   = 1'b0;
    m_a    = '0;
    m_d    = '0;
    w_busy = 1'b0;
    unique case (r_state)
      S_RD: begin
        m_req  = 1'b1;
        w_busy = 1'b1;
        m_a    = r_wsrc;
      end
      S_WR: begin
        m_req  = 1'b1;
        w_busy = 1'b1;
        m_we   = m_gnt;
        m_a    = r_wdst;
        m_d    = r_buf;
      end
      default: ;
    endcase
  end

  // Addresses wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wsrc <= '0;
      r_wdst <= '0;
      r_wcnt <= '0;
      r_buf  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_start) begin
            r_wsrc <= w_src;
            r_wdst <= w_dst;
            r_wcnt <= w_len;
          end
        S_RD:
          if (m_gnt) r_buf <= m_q;
        S_WR:
          if (m_gnt) begin
            r_wsrc <= r_wsrc + AW'(1);
            r_wdst <= r_wdst + AW'(1);
            r_wcnt <= r_wcnt - LW'(1);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: random transfers checked
// against an array copy model, grant stalls, busy writes, reset.
module tb_dma_engine;

  localparam int AW = 6;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    A;
  logic          WE;
  logic [31:0]   WD;
  logic [31:0]   RD;
  logic          m_req;
  logic          m_gnt;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [31:0]   m_d;
  logic [31:0]   m_q;

  logic [31:0]   mem  [64];
  logic [31:0]   expm [64];
  logic [AW-1:0] wlog [$];
  logic [AW-1:0] rlog [$];
  int            req_cnt = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            exp_err = 1'b0;

  dma_engine #(.AW(AW), .LW(LW)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .WE    (WE),
    .WD    (WD),
    .RD    (RD),
    .m_req (m_req),
    .m_gnt (m_gnt),
    .m_we  (m_we),
    .m_a   (m_a),
    .m_d   (m_d),
    .m_q   (m_q)
  );

  always #5 clk = ~clk;

  assign m_q = mem[m_a];

  always @(posedge clk) begin
    if (m_req) req_cnt++;
    if (m_we) begin
      mem[m_a] = m_d;
      wlog.push_back(m_a);
    end else if (m_req && m_gnt) begin
      rlog.push_back(m_a);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    A = a; WD = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; A = 2'd3;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = RD;
  endtask

  // mode 0: grant always, 1: random grant, 2: 5-cycle stall
  task automatic run_xfer(input int src, input int dst,
                          input int len, input int mode,
                          input bit bwr);
    logic [31:0]   v;
    logic [AW-1:0] hold;
    int cyc, stalls, c0;
    hold = '0;
    wr(2'd0, src);
    wr(2'd1, dst);
    wr(2'd2, len);
    wr(2'd3, 32'h2);
    rd(2'd0, v); chk("src_rb", v, src);
    rd(2'd1, v); chk("dst_rb", v, dst);
    rd(2'd2, v); chk("len_rb", v, len);
    rd(2'd3, v); chk("stat_pre", v, {exp_err, 2'b00});
    for (int i = 0; i < 64; i++) expm[i] = mem[i];
    for (int i = 0; i < len; i++)
      expm[(dst + i) % 64] = expm[(src + i) % 64];
    wlog.delete();
    rlog.delete();
    m_gnt = 1'b1;
    c0 = req_cnt;
    wr(2'd3, 32'h1);
    exp_err = 1'b0;
    cyc = 0;
    stalls = 0;
    while (1) begin
      WE = 1'b0; A = 2'd3;
      #1;
      if (RD[0] == 1'b0) break;
      if (cyc > 2000) begin
        chk("busy_timeout", 1, 0);
        break;
      end
      case (mode)
        1: m_gnt = ($urandom_range(0, 3) != 0);
        2: m_gnt = !(cyc >= 3 && cyc < 8);
        default: m_gnt = 1'b1;
      endcase
      if (!m_gnt) stalls++;
      if (bwr && cyc == 2) begin
        WE = 1'b1; A = 2'd1; WD = 32'd40;
        exp_err = 1'b1;
      end
      #1;
      if (!m_gnt) chk("stall_we", m_we, 0);
      if (mode == 2 && cyc == 3) hold = m_a;
      if (mode == 2 && cyc > 3 && cyc < 8)
        chk("stall_ma", m_a, hold);
      @(negedge clk);
      cyc++;
    end
    WE = 1'b0;
    m_gnt = 1'b1;
    chk("busy_cyc", cyc, 2 * len + stalls);
    chk("req_cyc", req_cnt - c0, 2 * len + stalls);
    rd(2'd3, v); chk("stat_end", v, {exp_err, 2'b10});
    rd(2'd1, v); chk("dst_keep", v, dst);
    chk("idle_ma", m_a, 0);
    chk("idle_md", m_d, 0);
    chk("idle_req", {m_req, m_we}, 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("mem%0d", i), mem[i], expm[i]);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    rst = 1'b1; WE = 1'b0; A = 2'd3; WD = '0; m_gnt = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      chk($sformatf("rst_rd%0d", a), v, 0);
    end
    chk("rst_req", {m_req, m_we}, 0);
    chk("rst_ma", m_a, 0);
    chk("rst_md", m_d, 0);

    mem[4] = 32'd11; mem[5] = 32'd22; mem[6] = 32'd33;
    run_xfer(4, 20, 3, 0, 1'b0);
    chk("basic20", mem[20], 32'd11);
    chk("basic21", mem[21], 32'd22);
    chk("basic22", mem[22], 32'd33);

    run_xfer(7, 9, 0, 0, 1'b0);
    chk("zero_wr", wlog.size(), 0);

    run_xfer(62, 10, 3, 0, 1'b0);
    chk("wrap_nr", rlog.size(), 3);
    chk("wrap_nw", wlog.size(), 3);
    if (rlog.size() == 3 && wlog.size() == 3) begin
      chk("wrap_r0", rlog[0], 62);
      chk("wrap_r1", rlog[1], 63);
      chk("wrap_r2", rlog[2], 0);
      chk("wrap_w0", wlog[0], 10);
      chk("wrap_w1", wlog[1], 11);
      chk("wrap_w2", wlog[2], 12);
    end

    run_xfer($urandom_range(0, 63), $urandom_range(0, 63),
             6, 2, 1'b0);

    run_xfer(1, 30, 4, 0, 1'b1);

    for (int t = 0; t < 12; t++)
      run_xfer($urandom_range(0, 63), $urandom_range(0, 63),
               $urandom_range(0, 64), 1, 1'b0);

    wr(2'd0, 32'd2);
    wr(2'd1, 32'd50);
    wr(2'd2, 32'd5);
    wlog.delete();
    m_gnt = 1'b1;
    wr(2'd3, 32'h1);
    n = 0;
    while (wlog.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_seen", wlog.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      chk($sformatf("rst_mid_rd%0d", a), v, 0);
    end
    chk("rst_mid_req", {m_req, m_we}, 0);
    repeat (20) @(negedge clk);
    chk("rst_mid_nowr", wlog.size(), 2);
    chk("rst_mid_req2", m_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 Parameter AW, default 6: word-address width of the data-memory port, giving a 64-word memory.
REQ-002 Parameter LW, default 7: transfer-length width, allowing lengths 0..64.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port A, input, 2: register select, driven from CPU address bits [3:2].
REQ-006 Port WE, input, 1: register write enable from the system address decoder.
REQ-007 Port WD, input, 32: register write data.
REQ-008 Port RD, output, 32: register read data, combinational from A.
REQ-009 Port m_req, output, 1: requests ownership of the data-memory port.
REQ-010 Port m_gnt, input, 1: grant from the arbiter; when low, the CPU owns dmem.
REQ-011 Port m_we, output, 1: data-memory write enable.
REQ-012 Port m_a, output, AW: data-memory word address.
REQ-013 Port m_d, output, 32: data-memory write data.
REQ-014 Port m_q, input, 32: data-memory read data; combinational with m_a.

Function
REQ-015 Register map SHALL be:
- A=0: SRC, word address, AW bits.
- A=1: DST, word address, AW bits.
- A=2: LEN, LW bits.
- A=3: CTRL/STATUS.
REQ-016 CTRL/STATUS writes SHALL act as follows:
- WD[0]=1: GO.
- WD[1]=1: clears DONE.
REQ-017 CTRL/STATUS reads SHALL return {29'b0, ERR, DONE, BUSY}.
REQ-018 SRC, DST and LEN reads SHALL be zero-extended to 32 bits.
REQ-019 FSM states SHALL be IDLE, RD and WR.
REQ-020 GO in IDLE with LEN>0 SHALL, at the next edge:
- load working copies of SRC, DST and LEN;
- clear DONE and ERR;
- enter RD.
REQ-021 GO in IDLE with LEN=0 SHALL set DONE at the next edge, remain in IDLE and make no memory access.
REQ-022 In RD with m_gnt=1:
- m_a SHALL be the working source address;
- m_q SHALL be latched into the 32-bit data buffer at the edge;
- the FSM SHALL go to WR.
REQ-023 In WR with m_gnt=1:
- m_a SHALL be the working destination address;
- m_d SHALL be the buffer;
- m_we SHALL be 1;
- at the edge, both working addresses SHALL increment, the count SHALL decrement, and the FSM SHALL go to RD, or to IDLE with DONE=1 if the count reaches 0.
REQ-024 In RD or WR with m_gnt=0, the FSM SHALL hold state and all working registers, and m_we SHALL be 0.
REQ-025 m_req SHALL be 1 exactly in states RD and WR.
REQ-026 BUSY SHALL be 1 exactly in states RD and WR.
REQ-027 With m_gnt held high, BUSY SHALL stay high for exactly 2*LEN cycles.
REQ-028 Working addresses SHALL wrap modulo 2^AW, e.g. 63+1 gives 0.
REQ-029 Writes to A=0, A=1, A=2, or GO, while BUSY SHALL be ignored, the register SHALL keep its value, and ERR SHALL be set (sticky).
REQ-030 A WD[1] clear of DONE while BUSY SHALL be honoured.
REQ-031 DONE and ERR SHALL stay set until cleared by GO, a WD[1] write, or reset.
REQ-032 When GO is accepted in the same cycle as a WD[1] write, the GO behaviour SHALL take priority.
REQ-033 m_a, m_d and m_we SHALL be 0 in IDLE.

Reset
REQ-034 rst=1 at an edge SHALL force, including mid-transfer:
- state IDLE;
- SRC, DST, LEN, working copies and buffer all 0;
- BUSY, DONE and ERR all 0.
REQ-035 After reset, m_req=0, m_we=0, m_a=0, m_d=0 and RD reads 0 for every A.
REQ-036 Any transfer interrupted by reset SHALL NOT resume.

Structure
REQ-037 Package dma_pkg SHALL hold:
- the FSM state enum;
- register index constants REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3;
- CTRL/STATUS bit positions.
REQ-038 Sub-module dma_regs SHALL hold the register file, read mux and ERR/DONE flag logic.
REQ-039 The FSM and datapath SHALL reside in dma_engine.

Verification
REQ-040 Basic copy:
- stimulus: mem[4..6]=11,22,33; SRC=4, DST=20, LEN=3; GO; m_gnt=1.
- response: mem[20..22]=11,22,33; BUSY high for 6 cycles; then STATUS=0x2.
REQ-041 Zero length:
- stimulus: LEN=0, GO.
- response: STATUS=0x2 next cycle; m_req and m_we never asserted.
REQ-042 Wrap-around:
- stimulus: SRC=62, DST=10, LEN=3.
- response: reads from 62, 63, 0; writes to 10, 11, 12.
REQ-043 Grant stall:
- stimulus: m_gnt=0 for 5 cycles in the middle of a transfer.
- response: no m_we during the stall; state and addresses frozen; final memory contents correct; BUSY lasts 2*LEN+5 cycles.
REQ-044 Busy write:
- stimulus: write DST=40 while BUSY.
- response: DST unchanged; STATUS bit2=1 after completion.
REQ-045 Reset mid-transfer:
- stimulus: rst for 1 cycle after the 2nd word is written.
- response: all registers 0; m_req=0; no further writes to memory.
